// File: rtl/count_pkg.sv
// Shared definitions for the count_nbit counter family.
//   CNT_WRAP / CNT_SAT : end-of-range behaviour selectors for the SATURATE parameter
//   term_val()         : last legal count value for a given modulus
package count_pkg;

    localparam int CNT_WRAP = 0;
    localparam int CNT_SAT  = 1;

    // MODULUS may be 2**32 when WIDTH is 32, so the arithmetic is done in 64 bits.
    function automatic longint term_val(input longint modulus);
        return modulus - 64'sd1;
    endfunction

endpackage

// File: rtl/count_next.sv
// Next-state function of the N-bit up/down modulo counter (purely combinational).
// Ports:
//   cnt       in  current count
//   en        in  count enable
//   up        in  direction, 1 = increment
//   ld        in  parallel load request
//   din       in  load value (clamped to MODULUS-1 when out of range)
//   clr       in  synchronous clear, highest priority
//   next_cnt  out count value for the next edge
//   next_wrap out wrap pulse value for the next cycle
//   ovf_set   out request to set the sticky overflow flag
module count_next
    import count_pkg::*;
#(
    parameter int     WIDTH    = 4,
    parameter longint MODULUS  = 16,
    parameter int     SATURATE = CNT_WRAP
) (
    input  logic [WIDTH-1:0] cnt,
    input  logic             en,
    input  logic             up,
    input  logic             ld,
    input  logic [WIDTH-1:0] din,
    input  logic             clr,
    output logic [WIDTH-1:0] next_cnt,
    output logic             next_wrap,
    output logic             ovf_set
);

    localparam logic [WIDTH-1:0] TERM  = WIDTH'(term_val(MODULUS));
    localparam logic [63:0]      MOD_U = 64'(MODULUS);

    logic w_at_top;
    logic w_at_bot;
    logic w_din_ok;

    assign w_at_top = (cnt == TERM);
    assign w_at_bot = (cnt == '0);
    // Compare in 64 bits so a full-range modulus (2**WIDTH) never overflows the check.
    assign w_din_ok = (64'(din) < MOD_U);

    always_comb begin
        next_cnt  = cnt;
        next_wrap = 1'b0;
        ovf_set   = 1'b0;
        if (clr) begin
            next_cnt = '0;
        end else if (ld) begin
            if (w_din_ok) begin
                next_cnt = din;
            end else begin
                next_cnt = TERM;
                ovf_set  = 1'b1;
            end
        end else if (en) begin
            if (up) begin
                if (w_at_top) begin
                    ovf_set = 1'b1;
                    if (SATURATE == CNT_WRAP) begin
                        next_cnt  = '0;
                        next_wrap = 1'b1;
                    end
                end else begin
                    next_cnt = cnt + WIDTH'(1);
                end
            end else begin
                if (w_at_bot) begin
                    ovf_set = 1'b1;
                    if (SATURATE == CNT_WRAP) begin
                        next_cnt  = TERM;
                        next_wrap = 1'b1;
                    end
                end else begin
                    next_cnt = cnt - WIDTH'(1);
                end
            end
        end
    end

endmodule

// File: rtl/count_nbit.sv
// N-bit up/down modulo counter with load, clear, wrap/saturate mode,
// terminal-count decode, wrap pulse and sticky overflow.
// Ports:
//   clk  in  rising-edge clock
//   res  in  asynchronous active-high reset
//   clr  in  synchronous clear (beats ld and en)
//   ld   in  synchronous parallel load (beats en)
//   din  in  load value
//   en   in  count enable
//   up   in  direction, 1 = increment
//   cnt  out registered count
//   tc   out terminal count for the current direction (combinational)
//   wrap out one-cycle pulse after a wrapping edge
//   ovf  out sticky overflow, cleared only by clr or res
module count_nbit
    import count_pkg::*;
#(
    parameter int     WIDTH    = 4,
    parameter longint MODULUS  = 16,
    parameter int     SATURATE = CNT_WRAP
) (
    input  logic             clk,
    input  logic             res,
    input  logic             clr,
    input  logic             ld,
    input  logic [WIDTH-1:0] din,
    input  logic             en,
    input  logic             up,
    output logic [WIDTH-1:0] cnt,
    output logic             tc,
    output logic             wrap,
    output logic             ovf
);

    localparam logic [WIDTH-1:0] TERM = WIDTH'(term_val(MODULUS));

    if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
        $error("count_nbit: WIDTH must be 1..32");
    end
    if (MODULUS < 2 || MODULUS > (longint'(1) << WIDTH)) begin : g_bad_modulus
        $error("count_nbit: MODULUS must be 2..2**WIDTH");
    end
    if (SATURATE != CNT_WRAP && SATURATE != CNT_SAT) begin : g_bad_mode
        $error("count_nbit: SATURATE must be 0 or 1");
    end

    logic [WIDTH-1:0] r_cnt;
    logic             r_wrap;
    logic             r_ovf;
    logic [WIDTH-1:0] w_next_cnt;
    logic             w_next_wrap;
    logic             w_ovf_set;

    count_next #(
        .WIDTH    (WIDTH),
        .MODULUS  (MODULUS),
        .SATURATE (SATURATE)
    ) u_next (
        .cnt       (r_cnt),
        .en        (en),
        .up        (up),
        .ld        (ld),
        .din       (din),
        .clr       (clr),
        .next_cnt  (w_next_cnt),
        .next_wrap (w_next_wrap),
        .ovf_set   (w_ovf_set)
    );

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            r_cnt  <= '0;
            r_wrap <= 1'b0;
            r_ovf  <= 1'b0;
        end else begin
            r_cnt  <= w_next_cnt;
            r_wrap <= w_next_wrap;
            if (clr) begin
                r_ovf <= 1'b0;
            end else if (w_ovf_set) begin
                r_ovf <= 1'b1;
            end
        end
    end

    assign cnt  = r_cnt;
    assign wrap = r_wrap;
    assign ovf  = r_ovf;
    assign tc   = up ? (r_cnt == TERM) : (r_cnt == '0);

endmodule

// File: doc/count_nbit.md
Name: count_nbit

Overview:
- Parametrised successor to the team's fixed 2-bit enable counter: an N-bit up/down modulo counter.
- Adds programmable modulus, direction control, parallel load, synchronous clear, wrap/saturate mode, terminal-count flag, wrap pulse and a sticky overflow flag.
- Keeps the split into a registered state plus a combinational next-state function.
- Used as a building block for timers, divider chains and sequencers in the same design.

Parameters:
- WIDTH, 4, counter width in bits (1..32).
- MODULUS, 16, count range 0..MODULUS-1. Legal range is 2..2**WIDTH; the RTL checks it at elaboration.
- SATURATE, 0. 0 = wrap at the ends of the range; 1 = hold at the ends of the range.

Ports:
- clk  input  1  rising-edge clock.
- res  input  1  asynchronous, active-high reset.
- clr  input  1  synchronous clear to 0.
- ld  input  1  synchronous parallel load.
- din  input  WIDTH  load value.
- en  input  1  count enable.
- up  input  1  direction: 1 = increment, 0 = decrement.
- cnt  output  WIDTH  current count (registered).
- tc  output  1  terminal count (combinational from cnt and up).
- wrap  output  1  one-cycle pulse (registered).
- ovf  output  1  sticky overflow (registered).

Behaviour:
- Reset: one clock; reset is asynchronous and active-high (res). While res=1: cnt=0, wrap=0, ovf=0, regardless of clk.
- Priority per rising edge: res > clr > ld > en. If none are active, cnt holds.
- clr=1: cnt<=0, wrap<=0, ovf<=0.
- ld=1 (clr=0):
  - cnt<=din if din<MODULUS; otherwise cnt<=MODULUS-1 (clamped) and ovf<=1.
  - wrap<=0.
  - en is ignored in that cycle.
- en=1, up=1, cnt<MODULUS-1: cnt<=cnt+1.
- en=1, up=1, cnt==MODULUS-1:
  - SATURATE=0: cnt<=0, wrap<=1, ovf<=1.
  - SATURATE=1: cnt holds, wrap<=0, ovf<=1.
- en=1, up=0, cnt>0: cnt<=cnt-1.
- en=1, up=0, cnt==0:
  - SATURATE=0: cnt<=MODULUS-1, wrap<=1, ovf<=1.
  - SATURATE=1: cnt holds, wrap<=0, ovf<=1.
- wrap is 1 for exactly the cycle after a wrapping edge. It is deasserted on every other edge, including when en=0.
- ovf stays set until clr or res. Multiple events keep it at 1.
- tc = en-independent flag: (up && cnt==MODULUS-1) || (!up && cnt==0). It changes combinationally with up.
- When MODULUS==2**WIDTH, wrap uses the natural WIDTH-bit roll-over. No wider intermediate result may be stored in cnt.
- Direction change takes effect on the same edge; there is no pipeline and latency is 1 cycle from input to cnt.
- Reset asserted mid-count zeroes all state immediately. After res deasserts, the first edge with en=1 counts from 0.
- Simultaneous clr and ld: clr wins and din is discarded.

Decomposition:
- Shared package count_pkg holds:
  - mode constants CNT_WRAP=0 and CNT_SAT=1;
  - a localparam function computing the terminal value for a given MODULUS.
- Sub-module count_next (purely combinational):
  - inputs: cnt, en, up, ld, din, clr;
  - outputs: next_cnt, next_wrap, ovf_set.
- count_nbit instantiates count_next and holds only the cnt, wrap and ovf registers plus the tc decode.

Test Plan (WIDTH=3, MODULUS=6 unless noted):
- Reset: pulse res mid-count at cnt=4, asynchronously between edges -> cnt=0, wrap=0 and ovf=0 before the next clk edge.
- Wrap up, SATURATE=0: en=1, up=1 for 7 edges from 0 -> cnt sequence 1,2,3,4,5,0,1. tc=1 while cnt=5. wrap=1 only in the cycle cnt=0. ovf=1 thereafter.
- Wrap down, SATURATE=0: load 1, then en=1, up=0 for 3 edges -> cnt 0,5,4. wrap pulses once at cnt=5. ovf=1.
- Saturate, SATURATE=1: up-count from 4 for 4 edges -> cnt 5,5,5,5. wrap stays 0. ovf=1 from the second edge at 5.
- Load and priority:
  - ld=1, din=7 -> cnt=5 and ovf=1.
  - ld=1, din=3 -> cnt=3.
  - clr=1 with ld=1, din=2 -> cnt=0, ovf=0.
  - ld=1 with en=1 -> the load wins and there is no count.
- Full range (WIDTH=4, MODULUS=16): up-count from 15 -> cnt=0 with a wrap pulse. Down from 0 -> cnt=15. en=0 for 3 edges -> cnt holds and wrap=0.
